pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Sequences the 5-stage pipeline around hazards the operand-forwarding path cannot resolve. Detects load-use hazards and inserts one bubble. Flushes wrong-path instructions on a taken branch resolved in EX. Freezes the front end while a fixed-latency multiply/divide unit (MDU) occupies EX. Sits beside the forwarding logic and drives the PC, IF/ID, ID/EX and EX/MEM register enables. Exports a saturating stall-cycle performance counter.

## Interface
- MDU_CYCLES, 4, MDU latency in cycles from dispatch to result valid; legal range 2..16
- CNT_W, 16, width of the stall performance counter
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ID_rs  in  5  source register rs of the instruction in ID
- ID_rt  in  5  source register rt of the instruction in ID
- ID_UsesRt  in  1  instruction in ID reads rt
- ID_MduOp  in  1  instruction in ID is an MDU operation
- EX_MemRead  in  1  instruction in EX is a load
- EX_WriteRegister  in  5  destination register of the instruction in EX
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle
- Perf_Clear  in  1  synchronous clear of Stall_Count
- PC_Write  out  1  PC load enable
- IF_ID_Write  out  1  IF/ID load enable
- IF_ID_Flush  out  1  IF/ID loads a NOP
- ID_EX_Write  out  1  ID/EX load enable
- ID_EX_Bubble  out  1  ID/EX loads a NOP; all control bits are zero
- EX_MEM_Bubble  out  1  EX/MEM loads a NOP
- MDU_Start  out  1  registered one-cycle start pulse to the MDU
- State  out  2  current state, for debug
- Stall_Count  out  CNT_W  cycles with PC_Write=0, saturating

## Operation
- States: RUN (2'b00) and MDU_WAIT (2'b01). Encodings 2'b10 and 2'b11 are illegal and return to RUN on the next clock edge.
- load_use = EX_MemRead & (EX_WriteRegister != 0) & ((EX_WriteRegister == ID_rs) | (ID_UsesRt & (EX_WriteRegister == ID_rt))).
- RUN outputs are combinational (Mealy). They are evaluated in the following priority order:
  1. EX_BranchTaken: PC_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1, IF_ID_Write=1. load_use and ID_MduOp are ignored, because those instructions are wrong-path.
  2. load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. Lasts exactly one cycle; no state change.
  3. Otherwise: PC_Write=1, IF_ID_Write=1, ID_EX_Write=1. All flush and bubble outputs are 0.
- ID_EX_Write=1 in every RUN cycle.
- MDU dispatch = RUN & ID_MduOp & !load_use & !EX_BranchTaken.
  - At that edge: state goes to MDU_WAIT, cnt loads MDU_CYCLES-1, MDU_Start is registered to 1.
- MDU_WAIT while cnt != 0:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0; EX holds the MDU op.
  - EX_MEM_Bubble=1; IF_ID_Flush=0, ID_EX_Bubble=0.
  - cnt decrements by 1 each cycle.
- MDU_WAIT with cnt == 0 (result valid):
  - All enables are 1 and all bubbles are 0; the result enters EX/MEM.
  - State goes to RUN at the next edge.
- EX_BranchTaken, load_use and ID_MduOp are ignored in MDU_WAIT.
- MDU_Start is 1 only in the first MDU_WAIT cycle.
- Stall_Count:
  - Increments each cycle PC_Write=0.
  - Saturates at 2^CNT_W-1.
  - Perf_Clear has priority over increment; after the edge the count is 0.
  - Stall_Count holds its value across state changes.
- Register 0 never creates a hazard.

## Timing
- Reset (rst_n low) forces, asynchronously:
  - State=RUN, cnt=0, MDU_Start=0, Stall_Count=0.
  - Combinational outputs are gated to safe values: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Bubble=1.
- First cycle after rst_n rises: normal RUN evaluation.
- Reset asserted mid-MDU_WAIT: abandons the operation immediately. The MDU shares rst_n, so no stale result is delivered.
- Load-use penalty: 1 cycle. Taken-branch penalty: 2 instructions killed, 0 stall cycles.
- MDU stall: MDU_CYCLES-1 cycles with PC_Write=0. A back-to-back MDU op dispatches in the release cycle; the RUN rules apply at the next edge.
- Branch and load-use in the same cycle: branch wins; Stall_Count does not increment.
- Perf_Clear in a stall cycle: the count is 0 after the edge; that cycle is not counted.

## Structure
- Shared package hazard_pkg:
  - State enum with RUN and MDU_WAIT encodings.
  - Width constant REG_ADDR_W=5.
  - NOP/bubble control constants shared with the pipeline registers.
- Sub-module hazard_perf_counter: CNT_W-wide saturating counter with clear and increment enable, reused for the future flush counter.
- Top level contains the hazard compare, the FSM with its cnt register, and the output mux.

## Test plan
- Reset release: with rst_n=0, outputs are PC_Write=0, ID_EX_Bubble=1, MDU_Start=0, Stall_Count=0. In the first cycle after release, with no hazard, PC_Write=1, ID_EX_Write=1, State=RUN.
- Load-use: EX_MemRead=1, EX_WriteRegister=5, ID_rs=5 for one cycle. Expect PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 1 cycle, Stall_Count=1. Repeat with EX_WriteRegister=0: no stall. Repeat with ID_rt=5 and ID_UsesRt=0: no stall.
- Branch over hazard: EX_BranchTaken=1 together with a load-use match and ID_MduOp=1. Expect IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, no MDU_Start, Stall_Count unchanged.
- MDU sequence, MDU_CYCLES=4: dispatch. Expect MDU_Start=1 in the first MDU_WAIT cycle only, then 3 cycles with PC_Write=0 and EX_MEM_Bubble=1, then 1 release cycle, then RUN. Stall_Count increases by 3. A back-to-back MDU op re-enters MDU_WAIT.
- Reset mid-MDU: assert rst_n=0 during the second MDU_WAIT cycle. Expect immediate State=RUN, MDU_Start=0, cnt=0. After release, normal flow resumes.
- Saturation and clear with CNT_W=4: 20 stall cycles give Stall_Count=15. Perf_Clear during a stall gives Stall_Count=0 after the edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
// and the pipeline registers it steers.
//   state_t        - controller state encoding (RUN / MDU_WAIT)
//   REG_ADDR_W     - architectural register address width
//   NOP_*          - values the pipeline registers load when bubbled/flushed
//   load_use_hit() - load-use compare between the EX load and the ID sources
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_WAIT = 2'b01
  } state_t;

  // Bubble contents: an all-zero instruction word and all-zero control bits.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [7:0]  NOP_CTRL  = 8'h00;

  // Register 0 is hard-wired to zero, so a load targeting it never hazards.
  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] wr_reg,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rt
  );
    logic zero_dst;
    zero_dst     = (wr_reg == {REG_ADDR_W{1'b0}});
    load_use_hit = mem_read & ~zero_dst &
                   ((wr_reg == rs) | (uses_rt & (wr_reg == rt)));
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: CNT_W-wide saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear, wins over inc
//   inc        : count one event this cycle
//   count      : current value, sticks at all-ones
module hazard_perf_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Saturating counter with synchronous clear priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stalls/flushes a 5-stage pipeline for hazards
// forwarding cannot cover (load-use, taken branch in EX, multi-cycle MDU).
//   Inputs : ID_rs/ID_rt/ID_UsesRt/ID_MduOp (ID stage), EX_MemRead,
//            EX_WriteRegister, EX_BranchTaken (EX stage), Perf_Clear
//   Outputs: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
//            EX_MEM_Bubble (combinational), MDU_Start (registered pulse),
//            State (debug), Stall_Count (saturating stall cycles)
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_UsesRt,
  input  logic                  ID_MduOp,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_WriteRegister,
  input  logic                  EX_BranchTaken,
  input  logic                  Perf_Clear,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Write,
  output logic                  ID_EX_Bubble,
  output logic                  EX_MEM_Bubble,
  output logic                  MDU_Start,
  output logic [1:0]            State,
  output logic [CNT_W-1:0]      Stall_Count
);

  localparam int MDU_CNT_W = $clog2(MDU_CYCLES);

  state_t               state_r;
  logic [MDU_CNT_W-1:0] cnt_r;
  logic                 mdu_start_r;
  logic                 load_use_s;
  logic                 dispatch_s;
  logic                 pc_write_s;
  logic                 if_id_write_s;
  logic                 if_id_flush_s;
  logic                 id_ex_write_s;
  logic                 id_ex_bubble_s;
  logic                 ex_mem_bubble_s;

  assign load_use_s = load_use_hit(EX_MemRead, EX_WriteRegister, ID_rs, ID_rt, ID_UsesRt);
  // A wrong-path or load-stalled MDU op must not be dispatched.
  assign dispatch_s = (state_r == RUN) & ID_MduOp & ~load_use_s & ~EX_BranchTaken;

  // Controller FSM: MDU occupancy counter and the registered start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      cnt_r       <= {MDU_CNT_W{1'b0}};
      mdu_start_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (dispatch_s) begin
            state_r     <= MDU_WAIT;
            cnt_r       <= MDU_CNT_W'(MDU_CYCLES - 1);
            mdu_start_r <= 1'b1;
          end else begin
            state_r     <= RUN;
            cnt_r       <= cnt_r;
            mdu_start_r <= 1'b0;
          end
        end
        MDU_WAIT: begin
          mdu_start_r <= 1'b0;
          if (cnt_r != {MDU_CNT_W{1'b0}}) begin
            state_r <= MDU_WAIT;
            cnt_r   <= cnt_r - MDU_CNT_W'(1);
          end else begin
            state_r <= RUN;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r     <= RUN;
          cnt_r       <= {MDU_CNT_W{1'b0}};
          mdu_start_r <= 1'b0;
        end
      endcase
    end
  end

  // Output mux: Mealy decode in RUN, counter-driven freeze in MDU_WAIT.
  always_comb begin
    pc_write_s      = 1'b0;
    if_id_write_s   = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_write_s   = 1'b0;
    id_ex_bubble_s  = 1'b0;
    ex_mem_bubble_s = 1'b0;
    case (state_r)
      RUN: begin
        id_ex_write_s = 1'b1;
        if (EX_BranchTaken) begin
          pc_write_s     = 1'b1;
          if_id_write_s  = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_bubble_s = 1'b1;
        end else if (load_use_s) begin
          id_ex_bubble_s = 1'b1;
        end else begin
          pc_write_s    = 1'b1;
          if_id_write_s = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (cnt_r != {MDU_CNT_W{1'b0}}) begin
          ex_mem_bubble_s = 1'b1;
        end else begin
          pc_write_s    = 1'b1;
          if_id_write_s = 1'b1;
          id_ex_write_s = 1'b1;
        end
      end
      default: begin
        // Illegal encoding: hold the front end and bubble everything for the
        // single cycle before the FSM recovers to RUN.
        if_id_flush_s   = 1'b1;
        id_ex_bubble_s  = 1'b1;
        ex_mem_bubble_s = 1'b1;
      end
    endcase
  end

  // Reset gates the pipeline controls to "freeze and bubble" asynchronously.
  assign PC_Write      = rst_n & pc_write_s;
  assign IF_ID_Write   = rst_n & if_id_write_s;
  assign ID_EX_Write   = rst_n & id_ex_write_s;
  assign IF_ID_Flush   = ~rst_n | if_id_flush_s;
  assign ID_EX_Bubble  = ~rst_n | id_ex_bubble_s;
  assign EX_MEM_Bubble = ~rst_n | ex_mem_bubble_s;
  assign MDU_Start     = mdu_start_r;
  assign State         = state_r;

  hazard_perf_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (Perf_Clear),
    .inc   (~PC_Write),
    .count (Stall_Count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller (MDU_CYCLES=4, CNT_W=4).
// Inputs change 1ns after the rising edge, outputs are sampled 1ns later.
module tb_pipeline_hazard_controller;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_rs, ID_rt, EX_WriteRegister;
  logic       ID_UsesRt, ID_MduOp, EX_MemRead, EX_BranchTaken, Perf_Clear;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
  logic       ID_EX_Bubble, EX_MEM_Bubble, MDU_Start;
  logic [1:0] State;
  logic [3:0] Stall_Count;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_controller #(.MDU_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRt(ID_UsesRt), .ID_MduOp(ID_MduOp), .EX_MemRead(EX_MemRead),
    .EX_WriteRegister(EX_WriteRegister), .EX_BranchTaken(EX_BranchTaken),
    .Perf_Clear(Perf_Clear), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write),
    .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Bubble(EX_MEM_Bubble),
    .MDU_Start(MDU_Start), .State(State), .Stall_Count(Stall_Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0; ID_MduOp = 1'b0;
    EX_MemRead = 1'b0; EX_WriteRegister = 5'd0; EX_BranchTaken = 1'b0;
    Perf_Clear = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] wr, input logic [4:0] rs,
                              input logic [4:0] rt, input logic uses_rt);
    EX_MemRead = 1'b1; EX_WriteRegister = wr; ID_rs = rs; ID_rt = rt; ID_UsesRt = uses_rt;
  endtask

  // Checks a frozen MDU_WAIT cycle.
  task automatic check_mdu_stall(input string tag, input logic start_exp);
    check({tag, "_state"}, {30'd0, State}, 32'd1);
    check({tag, "_pc"}, {31'd0, PC_Write}, 32'd0);
    check({tag, "_ifid_w"}, {31'd0, IF_ID_Write}, 32'd0);
    check({tag, "_idex_w"}, {31'd0, ID_EX_Write}, 32'd0);
    check({tag, "_exmem_bub"}, {31'd0, EX_MEM_Bubble}, 32'd1);
    check({tag, "_start"}, {31'd0, MDU_Start}, {31'd0, start_exp});
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    idle_inputs();
    #3;
    // Reset values.
    check("rst_pc", {31'd0, PC_Write}, 32'd0);
    check("rst_ifid_w", {31'd0, IF_ID_Write}, 32'd0);
    check("rst_idex_w", {31'd0, ID_EX_Write}, 32'd0);
    check("rst_flush", {31'd0, IF_ID_Flush}, 32'd1);
    check("rst_idex_bub", {31'd0, ID_EX_Bubble}, 32'd1);
    check("rst_exmem_bub", {31'd0, EX_MEM_Bubble}, 32'd1);
    check("rst_start", {31'd0, MDU_Start}, 32'd0);
    check("rst_cnt", {28'd0, Stall_Count}, 32'd0);
    check("rst_state", {30'd0, State}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rel_pc", {31'd0, PC_Write}, 32'd1);
    check("rel_idex_w", {31'd0, ID_EX_Write}, 32'd1);
    check("rel_state", {30'd0, State}, 32'd0);

    // Load-use on rs.
    tick();
    set_load_use(5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    check("lu_pc", {31'd0, PC_Write}, 32'd0);
    check("lu_ifid_w", {31'd0, IF_ID_Write}, 32'd0);
    check("lu_bub", {31'd0, ID_EX_Bubble}, 32'd1);
    check("lu_idex_w", {31'd0, ID_EX_Write}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("lu_after_pc", {31'd0, PC_Write}, 32'd1);
    check("lu_after_bub", {31'd0, ID_EX_Bubble}, 32'd0);
    check("lu_cnt", {28'd0, Stall_Count}, 32'd1);

    // Register 0 destination: no hazard.
    set_load_use(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check("r0_pc", {31'd0, PC_Write}, 32'd1);
    // rt matches but is not read: no hazard.
    set_load_use(5'd5, 5'd3, 5'd5, 1'b0);
    #1;
    check("rt_unused_pc", {31'd0, PC_Write}, 32'd1);
    tick();
    check("no_stall_cnt", {28'd0, Stall_Count}, 32'd1);
    // rt matches and is read: stall.
    set_load_use(5'd5, 5'd3, 5'd5, 1'b1);
    #1;
    check("rt_used_pc", {31'd0, PC_Write}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("rt_used_cnt", {28'd0, Stall_Count}, 32'd2);

    // Taken branch overrides load-use and MDU dispatch.
    set_load_use(5'd7, 5'd7, 5'd0, 1'b0);
    EX_BranchTaken = 1'b1;
    ID_MduOp = 1'b1;
    #1;
    check("br_flush", {31'd0, IF_ID_Flush}, 32'd1);
    check("br_bub", {31'd0, ID_EX_Bubble}, 32'd1);
    check("br_pc", {31'd0, PC_Write}, 32'd1);
    check("br_ifid_w", {31'd0, IF_ID_Write}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("br_start", {31'd0, MDU_Start}, 32'd0);
    check("br_state", {30'd0, State}, 32'd0);
    check("br_cnt", {28'd0, Stall_Count}, 32'd2);

    // MDU dispatch: 3 frozen cycles, then release.
    ID_MduOp = 1'b1;
    #1;
    check("mdu_disp_pc", {31'd0, PC_Write}, 32'd1);
    tick();
    ID_MduOp = 1'b0;
    #1;
    check_mdu_stall("mdu_c1", 1'b1);
    tick();
    check_mdu_stall("mdu_c2", 1'b0);
    tick();
    check_mdu_stall("mdu_c3", 1'b0);
    tick();
    check("mdu_rel_state", {30'd0, State}, 32'd1);
    check("mdu_rel_pc", {31'd0, PC_Write}, 32'd1);
    check("mdu_rel_ifid_w", {31'd0, IF_ID_Write}, 32'd1);
    check("mdu_rel_idex_w", {31'd0, ID_EX_Write}, 32'd1);
    check("mdu_rel_exmem_bub", {31'd0, EX_MEM_Bubble}, 32'd0);
    check("mdu_rel_cnt", {28'd0, Stall_Count}, 32'd5);
    // Back-to-back MDU op waiting in ID.
    ID_MduOp = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (MDU_Start === 1'b1 && State === 2'd1) found = 1'b1;
    end
    check("b2b_reenter", {31'd0, found}, 32'd1);
    ID_MduOp = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (State === 2'd0) found = 1'b1;
    end
    check("b2b_return", {31'd0, found}, 32'd1);
    check("b2b_cnt", {28'd0, Stall_Count}, 32'd8);

    // Reset during the second MDU_WAIT cycle.
    ID_MduOp = 1'b1;
    tick();
    ID_MduOp = 1'b0;
    tick();
    check("mid_pre_state", {30'd0, State}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {30'd0, State}, 32'd0);
    check("mid_rst_start", {31'd0, MDU_Start}, 32'd0);
    check("mid_rst_pc", {31'd0, PC_Write}, 32'd0);
    check("mid_rst_cnt", {28'd0, Stall_Count}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_pc", {31'd0, PC_Write}, 32'd1);
    check("mid_rel_state", {30'd0, State}, 32'd0);
    ID_MduOp = 1'b1;
    tick();
    ID_MduOp = 1'b0;
    #1;
    check_mdu_stall("mid_redo", 1'b1);
    tick(); tick(); tick(); tick();
    check("mid_redo_state", {30'd0, State}, 32'd0);
    check("mid_redo_cnt", {28'd0, Stall_Count}, 32'd3);

    // Saturation: 20 more stall cycles on a 4-bit counter.
    set_load_use(5'd9, 5'd9, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", {28'd0, Stall_Count}, 32'd15);
    Perf_Clear = 1'b1;
    tick();
    check("clr_cnt", {28'd0, Stall_Count}, 32'd0);
    Perf_Clear = 1'b0;
    tick();
    check("clr_resume_cnt", {28'd0, Stall_Count}, 32'd1);
    idle_inputs();
    tick();
    check("final_cnt", {28'd0, Stall_Count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
